// File: rtl/sort4_feeder.sv
// Collects four unsigned elements, sorts them with a 3-stage compare-exchange network, and
// writes them alternately into the low/high half of inba. Option: SORT4_FEEDER_GRPCNT_EN adds grp_cnt.
module sort4_feeder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [1:0]         load,
  output logic [8*WIDTH-1:0] inba
`ifdef SORT4_FEEDER_GRPCNT_EN
  ,
  output logic [7:0]         grp_cnt
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    S1      = 2'd1,
    S2      = 2'd2,
    S3      = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     slot_r [4];
  logic [WIDTH-1:0]     slot_s [4];
  logic [1:0]           cnt_r, cnt_s;
  logic                 sel_r, sel_s;
  logic                 in_ready_r;
  logic [1:0]           load_r, load_s;
  logic [8*WIDTH-1:0]   inba_r, inba_s;
  logic [2*WIDTH-1:0]   pair_a_s, pair_b_s;
  logic [4*WIDTH-1:0]   half_s;

  // Returns {larger, smaller}; equal operands keep their order.
  function automatic logic [2*WIDTH-1:0] cmpx(input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] hi);
    logic [2*WIDTH-1:0] res;
    if (lo > hi) begin
      res = {lo, hi};
    end else begin
      res = {hi, lo};
    end
    return res;
  endfunction

  // Next-state, slot network and output-register inputs
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    load_s   = 2'b00;
    inba_s   = inba_r;
    pair_a_s = {(2*WIDTH){1'b0}};
    pair_b_s = {(2*WIDTH){1'b0}};
    half_s   = {(4*WIDTH){1'b0}};
    for (int i = 0; i < 4; i++) begin
      slot_s[i] = slot_r[i];
    end
    case (state_r)
      COLLECT: begin
        if (in_valid) begin
          slot_s[cnt_r] = in_data;
          if (cnt_r == 2'd3) begin
            cnt_s   = 2'd0;
            state_s = S1;
          end else begin
            cnt_s   = cnt_r + 2'd1;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      S1: begin
        pair_a_s  = cmpx(slot_r[0], slot_r[1]);
        pair_b_s  = cmpx(slot_r[2], slot_r[3]);
        slot_s[0] = pair_a_s[WIDTH-1:0];
        slot_s[1] = pair_a_s[2*WIDTH-1:WIDTH];
        slot_s[2] = pair_b_s[WIDTH-1:0];
        slot_s[3] = pair_b_s[2*WIDTH-1:WIDTH];
        state_s   = S2;
      end
      S2: begin
        pair_a_s  = cmpx(slot_r[0], slot_r[2]);
        pair_b_s  = cmpx(slot_r[1], slot_r[3]);
        slot_s[0] = pair_a_s[WIDTH-1:0];
        slot_s[2] = pair_a_s[2*WIDTH-1:WIDTH];
        slot_s[1] = pair_b_s[WIDTH-1:0];
        slot_s[3] = pair_b_s[2*WIDTH-1:WIDTH];
        state_s   = S3;
      end
      S3: begin
        pair_a_s  = cmpx(slot_r[1], slot_r[2]);
        slot_s[1] = pair_a_s[WIDTH-1:0];
        slot_s[2] = pair_a_s[2*WIDTH-1:WIDTH];
        // Lane 0 sits at the LSB, so the smallest element goes last in the concatenation.
        half_s    = {slot_r[3], pair_a_s, slot_r[0]};
        if (sel_r) begin
          inba_s[8*WIDTH-1:4*WIDTH] = half_s;
          load_s                    = 2'b10;
        end else begin
          inba_s[4*WIDTH-1:0]       = half_s;
          load_s                    = 2'b01;
        end
        sel_s   = ~sel_r;
        state_s = COLLECT;
      end
      default: begin
        state_s = COLLECT;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // State, slot and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= COLLECT;
      cnt_r      <= 2'd0;
      sel_r      <= 1'b0;
      in_ready_r <= 1'b1;
      load_r     <= 2'b00;
      inba_r     <= {(8*WIDTH){1'b0}};
      for (int i = 0; i < 4; i++) begin
        slot_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      sel_r      <= sel_s;
      in_ready_r <= (state_s == COLLECT);
      load_r     <= load_s;
      inba_r     <= inba_s;
      for (int i = 0; i < 4; i++) begin
        slot_r[i] <= slot_s[i];
      end
    end
  end

  assign in_ready = in_ready_r;
  assign load     = load_r;
  assign inba     = inba_r;

`ifdef SORT4_FEEDER_GRPCNT_EN
  logic [7:0] grp_cnt_r;

  // Emitted-group counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_cnt_r <= 8'd0;
    end else if (state_r == S3) begin
      grp_cnt_r <= grp_cnt_r + 8'd1;
    end else begin
      grp_cnt_r <= grp_cnt_r;
    end
  end

  assign grp_cnt = grp_cnt_r;
`endif

  sort4_feeder_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_ready (in_ready),
    .load     (load)
  );

endmodule

// Protocol properties of the sort4_feeder outputs.
module sort4_feeder_chk (
  input logic       clk,
  input logic       rst,
  input logic       in_ready,
  input logic [1:0] load
);

  a_load_not_both: assert property (@(posedge clk) disable iff (!rst) load != 2'b11);
  a_load_ready:    assert property (@(posedge clk) disable iff (!rst) (load != 2'b00) |-> in_ready);
  a_load_single:   assert property (@(posedge clk) disable iff (!rst) (load != 2'b00) |=> (load == 2'b00));

endmodule

// File: doc/sort4_feeder.md
SORT4_FEEDER -- requirements
Module: sort4_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of one unsigned element.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 Port: in_valid  input  1  upstream element present on in_data.
REQ-005 Port: in_data  input  WIDTH  unsigned element.
REQ-006 Port: in_ready  output  1  block accepts an element this cycle.
REQ-007 Port: load  output  2  one-cycle pulse; load[0] = low half of inba updated, load[1] = high half updated.
REQ-008 Port: inba  output  8*WIDTH  two sorted 4-element groups; lane i at [i*WIDTH +: WIDTH]; lanes 0-3 = group a, lanes 4-7 = group b; ascending within each group, lowest lane smallest.
REQ-009 Port (only with SORT4_FEEDER_GRPCNT_EN): grp_cnt  output  8  number of groups emitted.

Function
REQ-010 States: COLLECT, S1, S2, S3; no other states.
REQ-011 COLLECT: in_ready = 1; each edge with in_valid = 1 stores in_data in slot cnt (0..3) and increments cnt.
REQ-012 The edge accepting the 4th element (cnt = 3) moves to S1 and clears cnt to 0.
REQ-013 S1, S2, S3: in_ready = 0; in_valid ignored, no data captured.
REQ-014 S1 edge: compare-exchange slot pairs (0,1) and (2,3); next state S2.
REQ-015 S2 edge: compare-exchange (0,2) and (1,3); next state S3.
REQ-016 S3 edge: compare-exchange (1,2), write the result to the inba half selected by sel, assert load[sel] for the following cycle only, toggle sel, return to COLLECT.
REQ-017 Compare-exchange: unsigned; swap only if lower slot > upper slot (equal values never swap).
REQ-018 Latency: 4th element accepted at edge k -> inba half updated and load pulse visible after edge k+3, for exactly one cycle.
REQ-019 Throughput: one group per 7 cycles minimum (4 collect + 3 sort); in_ready returns high in the same cycle the load pulse is visible.
REQ-020 The inba half not selected holds its value; both halves hold until overwritten.
REQ-021 load is never 2'b11; load = 2'b00 in every cycle except the one after an S3 edge.
REQ-022 sel starts at 0 after reset: 1st group -> a/load[0], 2nd -> b/load[1], alternating thereafter.
REQ-023 Partial group (cnt < 4) waits indefinitely in COLLECT; no timeout, no flush.

Reset
REQ-024 rst = 0 asynchronously forces: state COLLECT, cnt 0, sel 0, all slots 0, inba 0, load 2'b00, grp_cnt 0; in_ready = 1 once rst = 1.
REQ-025 Reset asserted mid-collect or mid-sort discards the partial/in-flight group; no load pulse is produced for it.

Configuration
REQ-026 Macro SORT4_FEEDER_GRPCNT_EN defined: grp_cnt port present, incremented on each S3 edge, wraps 255 -> 0.
REQ-027 Macro SORT4_FEEDER_GRPCNT_EN undefined: grp_cnt port and counter absent; all other behaviour identical.

Verification
REQ-028 Reset, then feed 200, 0, 201, 0 on consecutive cycles -> 3 cycles later load = 01, inba lanes 0-3 = 0, 0, 200, 201, lanes 4-7 = 0.
REQ-029 Next feed 23, 1, 9, 1 -> load = 10, lanes 4-7 = 1, 1, 9, 23, lanes 0-3 unchanged at 0, 0, 200, 201.
REQ-030 Hold in_valid = 1 continuously with 5, 6, 7, 8, 9, ... -> in_ready low exactly 3 cycles per group, every value captured once; elements offered while in_ready = 0 are not captured.
REQ-031 Feed 255, 255, 0, 255 (max and ties) -> group 0, 255, 255, 255, no wrap or sign error.
REQ-032 Feed 3 elements, pulse rst low, feed 4, 3, 2, 1 -> single load = 01 with 1, 2, 3, 4; no pulse for the discarded partial group.
REQ-033 With SORT4_FEEDER_GRPCNT_EN, emit 257 groups -> grp_cnt = 1; reset -> grp_cnt = 0.
